// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_pkg / cdb_arbiter_if
//   Purpose: shared completion-packet type and the bundle of handshake/bus
//   signals between the functional units, the completion arbiter and the CDB.
//   Modports:
//     slave  - arbiter side: takes ex_valid_in/ex_packet_in, drives
//              ex_ready_out, ex_packet_out, ex_valid_out, grant_idx_out
//     master - FU/CDB side: the mirror image of slave
//   Signals:
//     ex_valid_in   [NUM_FU]        FU i has a completed packet
//     ex_packet_in  [NUM_FU]        FU i completion packet
//     ex_ready_out  [NUM_FU]        slot i accepts a packet this edge
//     ex_packet_out                 granted packet broadcast on the CDB
//     ex_valid_out                  ex_packet_out is a real completion
//     grant_idx_out [FU_IDX_W]      index of the granted slot
// -----------------------------------------------------------------------------
package cdb_pkg;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] alu_result;
    logic [4:0]  dest_reg_idx;
    logic        is_ZEROREG;
    logic        take_branch;
  } ex_packet_t;

endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU   = 4,
  parameter int FU_IDX_W = $clog2(NUM_FU)
);

  logic [NUM_FU-1:0]                      ex_valid_in;
  cdb_pkg::ex_packet_t [NUM_FU-1:0]       ex_packet_in;
  logic [NUM_FU-1:0]                      ex_ready_out;
  cdb_pkg::ex_packet_t                    ex_packet_out;
  logic                                   ex_valid_out;
  logic [FU_IDX_W-1:0]                    grant_idx_out;

  modport slave (
    input  ex_valid_in,
    input  ex_packet_in,
    output ex_ready_out,
    output ex_packet_out,
    output ex_valid_out,
    output grant_idx_out
  );

  modport master (
    output ex_valid_in,
    output ex_packet_in,
    input  ex_ready_out,
    input  ex_packet_out,
    input  ex_valid_out,
    input  grant_idx_out
  );

endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Purpose: completion arbiter between the functional units and the CDB.
//   Each FU owns a one-entry holding slot. One occupied slot per cycle is
//   granted (round-robin from rr_ptr) and broadcast; FUs are back-pressured
//   while their slot is full and not being granted. squash empties all slots.
//   Ports:
//     clock   in   clock, all state updates on posedge
//     reset   in   synchronous active-high reset (overrides everything)
//     squash  in   mispredict flush, clears all slots and drops inputs
//     cdb     if   cdb_arbiter_if.slave (FU completion ports + CDB output)
//   Configuration macro:
//     CDB_FIXED_PRIO_EN - grant goes to the lowest-index occupied slot and
//                         the round-robin pointer is held at zero.
//   Implementation note: every output is a pure function of the slot state.
//   Instead of decoding it combinationally after the flops, the same function
//   is evaluated on the next state and registered alongside it, so outputs
//   come straight from flops with identical cycle timing.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_FU   = 4,
  parameter int FU_IDX_W = $clog2(NUM_FU)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  cdb_arbiter_if.slave  cdb
);

  typedef cdb_pkg::ex_packet_t pkt_t;

  typedef struct packed {
    logic                found;
    logic [FU_IDX_W-1:0] idx;
  } pick_t;

  localparam logic [NUM_FU-1:0]   ONE_VEC  = {{(NUM_FU-1){1'b0}}, 1'b1};
  localparam logic [FU_IDX_W-1:0] LAST_IDX = FU_IDX_W'(NUM_FU - 1);

  // First occupied slot scanning ptr, ptr+1, ... mod NUM_FU. The loop runs
  // backwards so the earliest position in scan order is the last one written.
  function automatic pick_t pick_f(input logic [NUM_FU-1:0]   valid,
                                   input logic [FU_IDX_W-1:0] ptr);
    pick_t r;
    int    j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      j       = (int'(ptr) + k) % NUM_FU;
      r.idx   = valid[j] ? FU_IDX_W'(j) : r.idx;
      r.found = valid[j] | r.found;
    end
    return r;
  endfunction

  function automatic logic [NUM_FU-1:0] onehot_f(input pick_t p);
    return p.found ? (ONE_VEC << p.idx) : {NUM_FU{1'b0}};
  endfunction

  logic [NUM_FU-1:0]    slot_valid_q, slot_valid_d;
  pkt_t [NUM_FU-1:0]    slot_pkt_q,   slot_pkt_d;
  logic [FU_IDX_W-1:0]  rr_ptr_q,     rr_ptr_d;

  logic                 ex_valid_q,   ex_valid_d;
  pkt_t                 ex_packet_q,  ex_packet_d;
  logic [FU_IDX_W-1:0]  grant_idx_q,  grant_idx_d;
  logic [NUM_FU-1:0]    ex_ready_q,   ex_ready_d;

  pick_t                cur_s, nxt_s;
  logic [NUM_FU-1:0]    cur_gnt_s, nxt_gnt_s, ready_s, accept_s;

  // Next slot state from the current grant and accepted inputs, then the
  // output image of that next state.
  always_comb begin
    cur_s     = pick_f(slot_valid_q, rr_ptr_q);
    cur_gnt_s = onehot_f(cur_s);
    // A granted slot drains this edge, so it may be refilled on the same edge.
    ready_s   = ~slot_valid_q | cur_gnt_s;
    accept_s  = cdb.ex_valid_in & ready_s & {NUM_FU{~squash}};

    slot_valid_d = squash ? {NUM_FU{1'b0}}
                          : ((slot_valid_q & ~cur_gnt_s) | accept_s);
    slot_pkt_d   = slot_pkt_q;
    for (int i = 0; i < NUM_FU; i++) begin
      slot_pkt_d[i] = accept_s[i] ? cdb.ex_packet_in[i] : slot_pkt_q[i];
    end

`ifdef CDB_FIXED_PRIO_EN
    rr_ptr_d = {FU_IDX_W{1'b0}};
`else
    // Pointer moves past the winner even in a squash cycle.
    if (cur_s.found) begin
      rr_ptr_d = (cur_s.idx == LAST_IDX) ? {FU_IDX_W{1'b0}}
                                         : cur_s.idx + FU_IDX_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
`endif

    nxt_s       = pick_f(slot_valid_d, rr_ptr_d);
    nxt_gnt_s   = onehot_f(nxt_s);
    ex_valid_d  = |slot_valid_d;
    ex_packet_d = nxt_s.found ? slot_pkt_d[nxt_s.idx] : pkt_t'('0);
    grant_idx_d = nxt_s.found ? nxt_s.idx : {FU_IDX_W{1'b0}};
    ex_ready_d  = ~slot_valid_d | nxt_gnt_s;
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_q <= {NUM_FU{1'b0}};
      slot_pkt_q   <= '0;
      rr_ptr_q     <= {FU_IDX_W{1'b0}};
      ex_valid_q   <= 1'b0;
      ex_packet_q  <= '0;
      grant_idx_q  <= {FU_IDX_W{1'b0}};
      ex_ready_q   <= {NUM_FU{1'b1}};
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_pkt_q   <= slot_pkt_d;
      rr_ptr_q     <= rr_ptr_d;
      ex_valid_q   <= ex_valid_d;
      ex_packet_q  <= ex_packet_d;
      grant_idx_q  <= grant_idx_d;
      ex_ready_q   <= ex_ready_d;
    end
  end

  assign cdb.ex_valid_out  = ex_valid_q;
  assign cdb.ex_packet_out = ex_packet_q;
  assign cdb.grant_idx_out = grant_idx_q;
  assign cdb.ex_ready_out  = ex_ready_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset;
  logic squash;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_FU(N)) bus ();

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .cdb    (bus)
  );

  typedef struct {
    logic       sq;
    logic [3:0] vin;
    logic       ev;
    int         eidx;
    logic [3:0] erdy;
    int         es;
    int         ei;
  } vec_t;

  // reference model state
  bit         m_full [N];
  ex_packet_t m_pkt  [N];
  int         m_ptr;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic ex_packet_t mk_pkt(input int s, input int i);
    ex_packet_t p;
    p.npc          = 32'h0000_1000 + 32'(s * 4);
    p.alu_result   = 32'(s * 256 + i);
    p.dest_reg_idx = 5'(i + 1);
    p.is_ZEROREG   = (i == 3);
    p.take_branch  = s[0];
    return p;
  endfunction

  task automatic drive(input logic sq, input logic [3:0] vin, input int s);
    squash          = sq;
    bus.ex_valid_in = vin;
    for (int i = 0; i < N; i++) bus.ex_packet_in[i] = mk_pkt(s, i);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0000, 0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // grant = first occupied slot walking from the pointer around the ring
  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_model();
    int         g;
    logic [3:0] er;
    ex_packet_t ep;
    g  = m_grant();
    ep = '0;
    if (g >= 0) ep = m_pkt[g];
    for (int i = 0; i < N; i++) er[i] = !m_full[i] || (i == g);
    chk("rnd_valid", bus.ex_valid_out, g >= 0);
    chk("rnd_idx", bus.grant_idx_out, (g >= 0) ? g : 0);
    chk("rnd_ready", bus.ex_ready_out, er);
    chk("rnd_pkt", bus.ex_packet_out, ep);
  endtask

  initial begin
    vec_t       vt [10];
    ex_packet_t pend_pkt [N];
    bit         pend [N];
    logic [3:0] vin, rdy;
    logic       sq;
    int         g, exp_idx;

    // ---- 1: reset state ----
    do_reset();
    chk("rst_valid", bus.ex_valid_out, 1'b0);
    chk("rst_ready", bus.ex_ready_out, 4'b1111);
    chk("rst_idx", bus.grant_idx_out, 2'd0);
    chk("rst_pkt", bus.ex_packet_out, 71'd0);

`ifndef CDB_FIXED_PRIO_EN
    // ---- table: sq, vin, exp valid, exp idx, exp ready, exp pkt (step, fu) ----
    vt[0] = '{1'b0, 4'b0100, 1'b1, 2, 4'b1111, 0, 2};
    vt[1] = '{1'b0, 4'b0000, 1'b0, 0, 4'b1111, 0, 0};
    vt[2] = '{1'b0, 4'b1111, 1'b1, 3, 4'b1000, 2, 3};
    vt[3] = '{1'b0, 4'b0000, 1'b1, 0, 4'b1001, 2, 0};
    vt[4] = '{1'b0, 4'b0000, 1'b1, 1, 4'b1011, 2, 1};
    vt[5] = '{1'b1, 4'b0001, 1'b0, 0, 4'b1111, 0, 0};
    vt[6] = '{1'b0, 4'b1001, 1'b1, 3, 4'b1110, 6, 3};
    vt[7] = '{1'b0, 4'b1001, 1'b1, 0, 4'b0111, 6, 0};
    vt[8] = '{1'b0, 4'b0000, 1'b1, 3, 4'b1111, 7, 3};
    vt[9] = '{1'b0, 4'b0000, 1'b0, 0, 4'b1111, 0, 0};
    for (int v = 0; v < 10; v++) begin
      drive(vt[v].sq, vt[v].vin, v);
      step();
      chk($sformatf("tab%0d_valid", v), bus.ex_valid_out, vt[v].ev);
      chk($sformatf("tab%0d_idx", v), bus.grant_idx_out, vt[v].eidx);
      chk($sformatf("tab%0d_ready", v), bus.ex_ready_out, vt[v].erdy);
      chk($sformatf("tab%0d_pkt", v), bus.ex_packet_out,
          vt[v].ev ? mk_pkt(vt[v].es, vt[v].ei) : ex_packet_t'('0));
    end

    // ---- 3: all four loaded at once from pointer 0 ----
    do_reset();
    drive(1'b0, 4'b1111, 20);
    step();
    drive(1'b0, 4'b0000, 21);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("all4_idx%0d", c), bus.grant_idx_out, c);
      chk($sformatf("all4_pkt%0d", c), bus.ex_packet_out, mk_pkt(20, c));
      chk($sformatf("all4_rdy%0d", c), bus.ex_ready_out, (4'b0010 << c) - 4'd1);
      step();
    end
    chk("all4_drained", bus.ex_valid_out, 1'b0);

    // ---- 5: squash with slots 0,3 full and FU2 presenting ----
    do_reset();
    drive(1'b0, 4'b1001, 40);
    step();
    chk("sq_pre_idx", bus.grant_idx_out, 2'd0);
    drive(1'b1, 4'b0100, 41);
    step();
    chk("sq_valid", bus.ex_valid_out, 1'b0);
    chk("sq_ready", bus.ex_ready_out, 4'b1111);
    drive(1'b0, 4'b1111, 42);
    step();
    chk("sq_ptr_idx", bus.grant_idx_out, 2'd1);
    chk("sq_ptr_pkt", bus.ex_packet_out, mk_pkt(42, 1));
`endif

    // ---- 4: FU1 streams one packet per cycle ----
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 4'b0010, 30 + c);
      step();
      chk($sformatf("strm%0d_valid", c), bus.ex_valid_out, 1'b1);
      chk($sformatf("strm%0d_rdy1", c), bus.ex_ready_out[1], 1'b1);
      chk($sformatf("strm%0d_pkt", c), bus.ex_packet_out, mk_pkt(30 + c, 1));
    end
    drive(1'b0, 4'b0000, 0);
    step();
    chk("strm_end_valid", bus.ex_valid_out, 1'b0);

    // ---- 6: FU0 and FU3 always requesting ----
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 4'b1001, 50 + c);
      step();
`ifdef CDB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = (c % 2 == 0) ? 0 : 3;
`endif
      chk($sformatf("duo%0d_idx", c), bus.grant_idx_out, exp_idx);
      chk($sformatf("duo%0d_rdy3", c), bus.ex_ready_out[3], exp_idx == 3);
    end

    // mid-operation reset loses buffered completions
    reset = 1'b1;
    drive(1'b0, 4'b0000, 0);
    step();
    reset = 1'b0;
    chk("midrst_valid", bus.ex_valid_out, 1'b0);
    chk("midrst_ready", bus.ex_ready_out, 4'b1111);

    // ---- randomized run against the reference model ----
    do_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_pkt[i]  = '0;
      pend[i]   = 1'b0;
    end
    m_ptr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check_model();
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 3 != 0)) begin
          pend[i]                  = 1'b1;
          pend_pkt[i].npc          = $urandom;
          pend_pkt[i].alu_result   = $urandom;
          pend_pkt[i].dest_reg_idx = 5'($urandom);
          pend_pkt[i].is_ZEROREG   = 1'($urandom);
          pend_pkt[i].take_branch  = 1'($urandom);
        end
        vin[i] = pend[i];
        bus.ex_packet_in[i] = pend_pkt[i];
      end
      sq = ($urandom % 20 == 0);
      squash = sq;
      bus.ex_valid_in = vin;
      g = m_grant();
      for (int i = 0; i < N; i++) rdy[i] = !m_full[i] || (i == g);
      step();
      if (g >= 0) begin
        m_full[g] = 1'b0;
`ifdef CDB_FIXED_PRIO_EN
        m_ptr = 0;
`else
        m_ptr = (g + 1) % N;
`endif
      end
      for (int i = 0; i < N; i++) begin
        if (vin[i] && rdy[i]) begin
          pend[i] = 1'b0;
          if (!sq) begin
            m_full[i] = 1'b1;
            m_pkt[i]  = pend_pkt[i];
          end
        end
        if (sq) m_full[i] = 1'b0;
      end
    end
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
